mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage and the
// memory stage. One access is in flight at a time; every clock edge is an
// arbitration edge. Data has priority unless fetch has lost STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_ready,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGntIf = 2'd1,
    StGntD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic        if_elig;
  logic        d_elig;
  logic        fetch_first;

  // State and registered outputs; synchronous reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      starve_q    <= 4'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      mem_we_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= 16'd0;
      d_rdata_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Arbitration: a requester whose grant ends at this edge may not be re-granted.
  always_comb begin
    if_elig     = if_req && !if_flush && (state_q != StGntIf);
    d_elig      = d_req && (state_q != StGntD);
    fetch_first = (32'(starve_q) >= STARVE_LIMIT);

    if (if_elig && (!d_elig || fetch_first)) begin
      state_d = StGntIf;
    end else if (d_elig) begin
      state_d = StGntD;
    end else begin
      state_d = StIdle;
    end

    if ((state_d == StGntIf) || !if_req || if_flush) begin
      starve_d = 4'd0;
    end else if (if_elig && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Next values of the memory port and of the completion outputs.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (state_d)
      StGntIf: mem_addr_d = if_addr;
      StGntD: begin
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
        mem_we_d    = d_we;
      end
      default: ;
    endcase

    // A flushed fetch still reads memory but its result is dropped.
    if_ready_d = (state_q == StGntIf) && !if_flush;
    if_rdata_d = if_ready_d ? mem_rdata : if_rdata_q;
    d_ready_d  = (state_q == StGntD);
    d_rdata_d  = (d_ready_d && !mem_we_q) ? mem_rdata : d_rdata_q;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // Gated by reset so a store aborted by reset never reaches the memory edge.
  assign mem_we    = mem_we_q && !reset;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two protocol-obeying requesters, a
// behavioural memory, a transaction-level reference model and a scoreboard
// checked by an independent monitor on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned Limit  = 3;
  localparam int          NCycle = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, if_ready;
  logic [15:0] if_addr = 16'd0, if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ready;
  logic [15:0] d_addr = 16'd0, d_wdata = 16'd0, d_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  mem_port_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural unified memory: asynchronous read, synchronous write.
  logic [15:0] ram [0:63];
  assign mem_rdata = ram[mem_addr[5:0]];
  always @(posedge clk) if (mem_we === 1'b1) ram[mem_addr[5:0]] <= mem_wdata;

  // Reference model state (0 idle, 1 fetch owns memory, 2 data owns memory).
  int          m_state = 0;
  int          m_starve = 0;
  logic [15:0] m_addr = 16'd0, m_wdata = 16'd0;
  logic        m_we = 1'b0;
  logic [15:0] m_if_rdata = 16'd0, m_d_rdata = 16'd0;
  logic        exp_if_ready = 1'b0, exp_d_ready = 1'b0;
  logic [15:0] ref_mem [0:63];

  typedef struct packed {
    logic        is_if;
    logic [15:0] data;
  } resp_t;
  resp_t sb_q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs seen at that edge.
  task automatic model_edge(input bit rst);
    bit fetch_can, data_can, fetch_wins, data_wins;
    exp_if_ready = 1'b0;
    exp_d_ready  = 1'b0;
    if (rst) begin
      m_state = 0; m_starve = 0; m_addr = 16'd0; m_wdata = 16'd0; m_we = 1'b0;
      m_if_rdata = 16'd0; m_d_rdata = 16'd0;
      return;
    end
    // Finish whatever access owned the memory during the cycle just ended.
    if (m_state == 2) begin
      if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
      else m_d_rdata = ref_mem[m_addr[5:0]];
      exp_d_ready = 1'b1;
      sb_q.push_back('{is_if: 1'b0, data: m_d_rdata});
    end else if (m_state == 1 && !if_flush) begin
      m_if_rdata = ref_mem[m_addr[5:0]];
      exp_if_ready = 1'b1;
      sb_q.push_back('{is_if: 1'b1, data: m_if_rdata});
    end
    fetch_can  = if_req && !if_flush && m_state != 1;
    data_can   = d_req && m_state != 2;
    fetch_wins = fetch_can && (!data_can || m_starve >= int'(Limit));
    data_wins  = data_can && !fetch_wins;
    if (fetch_wins || !if_req || if_flush) m_starve = 0;
    else if (fetch_can && m_starve < 15) m_starve++;
    m_we = 1'b0;
    if (fetch_wins) begin
      m_state = 1; m_addr = if_addr;
    end else if (data_wins) begin
      m_state = 2; m_addr = d_addr; m_wdata = d_wdata; m_we = d_we;
    end else begin
      m_state = 0;
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each ready pulse.
  always @(negedge clk) begin
    resp_t r;
    chk("if_ready", {15'd0, if_ready}, {15'd0, exp_if_ready});
    chk("d_ready", {15'd0, d_ready}, {15'd0, exp_d_ready});
    chk("mem_we", {15'd0, mem_we}, {15'd0, m_we && !reset});
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    if (m_state != 0) chk("mem_addr", mem_addr, m_addr);
    if (m_state == 2) chk("mem_wdata", mem_wdata, m_wdata);
    if (if_ready === 1'b1 && d_ready === 1'b1) begin
      tests++; fails++;
      $display("FAIL both_ready: got both readies high, expected at most one");
    end
    if (if_ready === 1'b1 || d_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got a ready pulse, expected none pending");
      end else begin
        r = sb_q.pop_front();
        chk("sb_kind", {15'd0, if_ready}, {15'd0, r.is_if});
        chk("sb_data", (if_ready === 1'b1) ? if_rdata : d_rdata, r.data);
      end
    end
  end

  // Stimulus: two requesters obeying the hold-until-ready protocol.
  initial begin
    bit          rst, quiet, flush_v, f_pend, d_pend, dwe_v;
    logic [15:0] f_addr, da_v, dw_v;
    f_pend = 0; d_pend = 0; dwe_v = 0; flush_v = 0;
    f_addr = 16'd0; da_v = 16'd0; dw_v = 16'd0;
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    for (int cyc = 0; cyc < NCycle; cyc++) begin
      quiet = (cyc >= NCycle - 10);
      rst = (cyc < 3) ||
            (!quiet && m_state == 2 && m_we && $urandom_range(0, 5) == 0) ||
            (!quiet && $urandom_range(0, 399) == 0);
      flush_v = 1'b0;
      if (rst) begin
        f_pend = 0; d_pend = 0;
      end else if (!quiet) begin
        if (!f_pend) begin
          if ($urandom_range(0, 3) != 0) begin
            f_pend = 1; f_addr = 16'($urandom_range(0, 63));
          end
        end else if ($urandom_range(0, 11) == 0) begin
          flush_v = 1'b1;
        end
        if (!d_pend && $urandom_range(0, 2) != 0) begin
          d_pend = 1;
          dwe_v  = 1'($urandom_range(0, 1));
          da_v   = 16'($urandom_range(0, 63));
          dw_v   = 16'($urandom);
        end
      end
      reset    = rst;
      if_req   = f_pend;
      if_flush = flush_v;
      if_addr  = f_pend ? f_addr : 16'($urandom_range(0, 63));
      d_req    = d_pend;
      d_we     = d_pend ? dwe_v : 1'($urandom_range(0, 1));
      d_addr   = d_pend ? da_v : 16'($urandom_range(0, 63));
      d_wdata  = d_pend ? dw_v : 16'($urandom);
      // While a requester owns the memory its buses may wander; the latch must hold.
      if (m_state == 1) if_addr = 16'($urandom_range(0, 63));
      if (m_state == 2) begin
        d_addr = 16'($urandom_range(0, 63)); d_wdata = 16'($urandom);
        d_we = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      model_edge(rst);
      if (exp_if_ready || flush_v) f_pend = 0;
      if (exp_d_ready) d_pend = 0;
    end
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; if_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    for (int i = 0; i < 64; i++) chk("mem_word", ram[i], ref_mem[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
